// File: rtl/pg_uart_loader.sv
// UART program downloader: receives a framed 8N1 image and writes 16-bit words
// into the PG slave port of the program RAM, holding the CPU in reset meanwhile.
module pg_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned TIMEOUT_CYC  = 1000000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        pg_clk_i,
    input  logic        pg_rst_i,
    input  logic        uart_rx_i,
    output logic        pg_wen_o,
    output logic [15:0] pg_din_o,
    output logic [15:0] pg_adr_o,
    output logic        pg_done_o,
    output logic        pg_rst_o,
    output logic        pg_err_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CSUM} state_t;

    // ---------------- UART receiver ----------------
    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       rx_st_q, rx_st_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rx_valid, frame_err;

    always_ff @(posedge pg_clk_i) begin
        if (pg_rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            rx_st_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            sync1_q   <= uart_rx_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rx_st_q   <= rx_st_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rx_valid  = 1'b0;
        frame_err = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (prev_q && !sync2_q) rx_st_d = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid-start-bit was only a glitch
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    rx_st_d   = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    shreg_d   = {sync2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) rx_st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    rx_valid  = sync2_q;
                    frame_err = !sync2_q;
                    rx_st_d   = RX_IDLE;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // ---------------- Frame FSM ----------------
    state_t          st_q, st_d;
    logic [15:0]     cnt_q, cnt_d, addr_q, addr_d;
    logic [7:0]      sum_q, sum_d, lo_q, lo_d;
    logic            wen_q, wen_d, done_q, done_d, err_q, err_d, hold_q, hold_d;
    logic [15:0]     din_q, din_d, adr_q, adr_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    always_ff @(posedge pg_clk_i) begin
        if (pg_rst_i) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            addr_q <= '0;
            sum_q  <= '0;
            lo_q   <= '0;
            wen_q  <= 1'b0;
            din_q  <= '0;
            adr_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            hold_q <= 1'b0;
            tmo_q  <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            sum_q  <= sum_d;
            lo_q   <= lo_d;
            wen_q  <= wen_d;
            din_q  <= din_d;
            adr_q  <= adr_d;
            done_q <= done_d;
            err_q  <= err_d;
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        sum_d  = sum_q;
        lo_d   = lo_q;
        wen_d  = 1'b0;
        din_d  = din_q;
        adr_d  = adr_q;
        done_d = done_q;
        err_d  = err_q;
        hold_d = hold_q;
        tmo_d  = (st_q == IDLE || rx_valid) ? '0 : tmo_q + 1'b1;

        if (st_q != IDLE && (frame_err || (!rx_valid && tmo_q == TMO_END))) begin
            st_d   = IDLE;
            err_d  = 1'b1;
            hold_d = 1'b0;
        end else if (rx_valid) begin
            case (st_q)
                IDLE: begin
                    if (shreg_q == SYNC_BYTE) begin
                        st_d   = CNT_LO;
                        done_d = 1'b0;
                        err_d  = 1'b0;
                        hold_d = 1'b1;
                        addr_d = '0;
                        sum_d  = '0;
                    end
                end
                CNT_LO: begin
                    cnt_d = {8'h00, shreg_q};
                    sum_d = sum_q + shreg_q;
                    st_d  = CNT_HI;
                end
                CNT_HI: begin
                    cnt_d = {shreg_q, cnt_q[7:0]};
                    sum_d = sum_q + shreg_q;
                    st_d  = ({shreg_q, cnt_q[7:0]} == 16'd0) ? CSUM : DATA_LO;
                end
                DATA_LO: begin
                    lo_d  = shreg_q;
                    sum_d = sum_q + shreg_q;
                    st_d  = DATA_HI;
                end
                DATA_HI: begin
                    sum_d  = sum_q + shreg_q;
                    wen_d  = 1'b1;
                    din_d  = {shreg_q, lo_q};
                    adr_d  = addr_q;
                    addr_d = addr_q + 16'd1;
                    cnt_d  = cnt_q - 16'd1;
                    st_d   = (cnt_q == 16'd1) ? CSUM : DATA_LO;
                end
                CSUM: begin
                    done_d = (shreg_q == sum_q);
                    err_d  = (shreg_q != sum_q);
                    hold_d = 1'b0;
                    st_d   = IDLE;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    assign pg_wen_o  = wen_q;
    assign pg_din_o  = din_q;
    assign pg_adr_o  = adr_q;
    assign pg_done_o = done_q;
    assign pg_err_o  = err_q;
    // Hold-reset releases combinationally so the CPU is freed in the reset cycle itself
    assign pg_rst_o  = hold_q & ~pg_rst_i;

endmodule

// File: tb/tb_pg_uart_loader.sv
// Bench for pg_uart_loader: directed frame table, multi-cycle corner sequences
// and random frames checked against a frame-level reference model.
module tb_pg_uart_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned TMO = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        wen, done, hold, err;
    logic [15:0] din, adr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] wq[$];

    pg_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) dut (
        .pg_clk_i(clk), .pg_rst_i(rst), .uart_rx_i(rx),
        .pg_wen_o(wen), .pg_din_o(din), .pg_adr_o(adr),
        .pg_done_o(done), .pg_rst_o(hold), .pg_err_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wen) wq.push_back({adr, din});

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [0:11][7:0] bytes;
        int unsigned      len;
        int               badstop;
        int unsigned      nw;
        logic [0:1][31:0] w;
        logic             done;
        logic             err;
    } vec_t;

    vec_t vecs[6];

    task automatic check_frame(input string tag, input int unsigned nw, input logic [31:0] w[$],
                               input logic exp_done, input logic exp_err);
        check({tag, " nwrites"}, wq.size(), nw);
        for (int i = 0; i < nw && i < wq.size(); i++)
            check($sformatf("%s write%0d", tag, i), wq[i], w[i]);
        check({tag, " done"}, done, exp_done);
        check({tag, " err"},  err,  exp_err);
        check({tag, " rst"},  hold, 1'b0);
        if (nw > 0) check({tag, " hold adr/din"}, {adr, din}, w[nw-1]);
    endtask

    initial begin
        logic [31:0] ew[$];
        logic [7:0]  fr[$];
        logic [7:0]  s;
        logic [15:0] word;
        int unsigned n;
        logic        bad;

        vecs[0] = '{{8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'h16,8'h00,8'h00,8'h00,8'h00},
                    8, -1, 2, {32'h0000_1234, 32'h0001_5678}, 1'b1, 1'b0};
        vecs[1] = '{{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    4, -1, 0, {32'h0, 32'h0}, 1'b1, 1'b0};
        vecs[2] = '{{8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'h17,8'h00,8'h00,8'h00,8'h00},
                    8, -1, 2, {32'h0000_1234, 32'h0001_5678}, 1'b0, 1'b1};
        vecs[3] = '{{8'hA5,8'h01,8'h00,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    4, 3, 0, {32'h0, 32'h0}, 1'b0, 1'b1};
        vecs[4] = '{{8'h00,8'hFF,8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'h16,8'h00,8'h00},
                    10, -1, 2, {32'h0000_1234, 32'h0001_5678}, 1'b1, 1'b0};
        vecs[5] = '{{8'hA5,8'h01,8'h00,8'hA5,8'hA5,8'h4B,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    6, -1, 1, {32'h0000_A5A5, 32'h0}, 1'b1, 1'b0};

        repeat (4) @(negedge clk);
        check("reset outputs", {wen, din, adr, done, hold, err}, '0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            if (v == 4) begin
                // short low glitch in IDLE must not start a byte
                rx = 1'b0;
                repeat (5) @(negedge clk);
                rx = 1'b1;
                repeat (2 * CPB) @(negedge clk);
            end
            wq.delete();
            for (int b = 0; b < vecs[v].len; b++)
                send_byte(vecs[v].bytes[b], (b == vecs[v].badstop) ? 1'b0 : 1'b1);
            repeat (4) @(negedge clk);
            ew.delete();
            for (int i = 0; i < vecs[v].nw; i++) ew.push_back(vecs[v].w[i]);
            check_frame($sformatf("vec%0d", v), vecs[v].nw, ew, vecs[v].done, vecs[v].err);
        end

        // timeout inside a frame, then a clean frame
        wq.delete();
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        repeat (TMO - 150) @(negedge clk);
        check("pre-timeout err", err, 1'b0);
        check("pre-timeout rst", hold, 1'b1);
        repeat (200) @(negedge clk);
        check("timeout err", err, 1'b1);
        check("timeout rst", hold, 1'b0);
        check("timeout nwrites", wq.size(), 0);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        ew.delete(); ew.push_back(32'h0000_55AA);
        check_frame("after-timeout", 1, ew, 1'b1, 1'b0);

        // reset between low and high data byte
        wq.delete();
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        check("mid-frame rst high", hold, 1'b1);
        rst = 1'b1;
        #1;
        check("rst drops immediately", hold, 1'b0);
        @(negedge clk);
        check("mid-frame reset outputs", {wen, din, adr, done, hold, err}, '0);
        rst = 1'b0;
        send_byte(8'h55, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("post-reset nwrites", wq.size(), 0);
        check("post-reset flags", {done, err, hold}, 3'b000);

        // random frames against a frame-level model
        for (int r = 0; r < 6; r++) begin
            fr.delete(); ew.delete();
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                s = 8'($urandom_range(0, 255));
                fr.push_back((s == 8'hA5) ? 8'h5A : s);
            end
            n   = $urandom_range(0, 3);
            bad = ($urandom_range(0, 3) == 0);
            fr.push_back(8'hA5);
            fr.push_back(n[7:0]); fr.push_back(8'h00);
            s = n[7:0];
            for (int i = 0; i < n; i++) begin
                word = 16'($urandom);
                fr.push_back(word[7:0]); fr.push_back(word[15:8]);
                s = s + word[7:0] + word[15:8];
                ew.push_back({16'(i), word});
            end
            fr.push_back(bad ? s + 8'd1 : s);
            wq.delete();
            foreach (fr[k]) send_byte(fr[k], 1'b1);
            repeat (4) @(negedge clk);
            check_frame($sformatf("rand%0d", r), n, ew, !bad, bad);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
